// File: rtl/noc_ctrl_pkg.sv
// rtl/noc_ctrl_pkg.sv - shared types and default parameters for the NoC adder control path
package noc_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INIT_WAIT,
        PULSE1,
        PULSE2,
        WAIT_DONE,
        GAP,
        FINISH,
        ERR
    } inj_state_t;

    localparam int PKT_CNT_W = 16;

    localparam int DEF_NUM_PKT    = 10;
    localparam int DEF_INIT_DELAY = 12;
    localparam int DEF_GAP_CYCLES = 2;
    localparam int DEF_TIMEOUT    = 1024;
    localparam int DEF_LAT_W      = 16;
    localparam int DEF_SUM_W      = 32;

endpackage

// File: rtl/noc_lat_stats.sv
// rtl/noc_lat_stats.sv - per-run latency statistics with saturating accumulate
module noc_lat_stats #(
    parameter int LAT_W = 16,
    parameter int SUM_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             update,
    input  logic [LAT_W-1:0] lat_in,
    output logic [LAT_W-1:0] lat_last,
    output logic [LAT_W-1:0] lat_min,
    output logic [LAT_W-1:0] lat_max,
    output logic [SUM_W-1:0] lat_sum
);

    logic [LAT_W-1:0] lat_last_q, lat_last_d;
    logic [LAT_W-1:0] lat_min_q, lat_min_d;
    logic [LAT_W-1:0] lat_max_q, lat_max_d;
    logic [SUM_W-1:0] lat_sum_q, lat_sum_d;
    logic [SUM_W:0]   sum_ext;

    // Clear restores the empty-run values; update folds one latency in, sum clamps at all ones.
    always_comb begin
        lat_last_d = lat_last_q;
        lat_min_d  = lat_min_q;
        lat_max_d  = lat_max_q;
        lat_sum_d  = lat_sum_q;
        sum_ext    = {1'b0, lat_sum_q} + (SUM_W+1)'(lat_in);
        if (clear) begin
            lat_last_d = '0;
            lat_min_d  = '1;
            lat_max_d  = '0;
            lat_sum_d  = '0;
        end else if (update) begin
            lat_last_d = lat_in;
            if (lat_in < lat_min_q) lat_min_d = lat_in;
            if (lat_in > lat_max_q) lat_max_d = lat_in;
            lat_sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
        end
    end

    // Statistic registers; min resets to all ones so the first sample always wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_last_q <= '0;
            lat_min_q  <= '1;
            lat_max_q  <= '0;
            lat_sum_q  <= '0;
        end else begin
            lat_last_q <= lat_last_d;
            lat_min_q  <= lat_min_d;
            lat_max_q  <= lat_max_d;
            lat_sum_q  <= lat_sum_d;
        end
    end

    assign lat_last = lat_last_q;
    assign lat_min  = lat_min_q;
    assign lat_max  = lat_max_q;
    assign lat_sum  = lat_sum_q;

endmodule

// File: rtl/noc_adder_initiator.sv
// rtl/noc_adder_initiator.sv - START/START2/DONE packet initiator with latency stats and watchdog
module noc_adder_initiator
    import noc_ctrl_pkg::*;
#(
    parameter int NUM_PKT    = DEF_NUM_PKT,
    parameter int INIT_DELAY = DEF_INIT_DELAY,
    parameter int GAP_CYCLES = DEF_GAP_CYCLES,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int LAT_W      = DEF_LAT_W,
    parameter int SUM_W      = DEF_SUM_W
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 EN,
    output logic                 START,
    output logic                 START2,
    input  logic                 DONE,
    output logic                 BUSY,
    output logic                 FINISHED,
    output logic                 ERROR,
    output logic [PKT_CNT_W-1:0] PKT_CNT,
    output logic [LAT_W-1:0]     LAT_LAST,
    output logic [LAT_W-1:0]     LAT_MIN,
    output logic [LAT_W-1:0]     LAT_MAX,
    output logic [SUM_W-1:0]     LAT_SUM
);

    if (NUM_PKT < 1) begin : g_bad_num_pkt
        $error("NUM_PKT must be at least 1");
    end
    if (longint'(TIMEOUT) >= (longint'(1) << LAT_W)) begin : g_bad_timeout
        $error("TIMEOUT must be below 2**LAT_W");
    end
    if (SUM_W < LAT_W) begin : g_bad_sum_w
        $error("SUM_W must be at least LAT_W");
    end

    inj_state_t           state_q, state_d;
    logic [31:0]          cnt_q, cnt_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic [PKT_CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic                 done_q, done_d;
    logic                 done_rise;
    logic                 stats_clear;
    logic                 stats_update;

    assign done_rise = DONE & ~done_q;

    // Next-state logic: delay/gap counting, latency counting and packet completion.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        lat_cnt_d    = lat_cnt_q;
        pkt_cnt_d    = pkt_cnt_q;
        done_d       = DONE;
        stats_clear  = 1'b0;
        stats_update = 1'b0;
        case (state_q)
            IDLE: begin
                if (EN) begin
                    stats_clear = 1'b1;
                    pkt_cnt_d   = '0;
                    cnt_d       = '0;
                    state_d     = (INIT_DELAY > 0) ? INIT_WAIT : PULSE1;
                end
            end
            INIT_WAIT: begin
                if (cnt_q == 32'(INIT_DELAY - 1)) state_d = PULSE1;
                else                              cnt_d   = cnt_q + 32'd1;
            end
            PULSE1: begin
                // The START cycle itself counts as latency 0, so the next cycle is 1.
                lat_cnt_d = LAT_W'(1);
                state_d   = PULSE2;
            end
            PULSE2: begin
                lat_cnt_d = lat_cnt_q + LAT_W'(1);
                state_d   = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (done_rise) begin
                    stats_update = 1'b1;
                    pkt_cnt_d    = pkt_cnt_q + PKT_CNT_W'(1);
                    cnt_d        = '0;
                    if (pkt_cnt_d == PKT_CNT_W'(NUM_PKT)) state_d = FINISH;
                    else if (GAP_CYCLES > 0)              state_d = GAP;
                    else                                  state_d = PULSE1;
                end else if (lat_cnt_q == LAT_W'(TIMEOUT)) begin
                    state_d = ERR;
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == 32'(GAP_CYCLES - 1)) state_d = PULSE1;
                else                              cnt_d   = cnt_q + 32'd1;
            end
            FINISH, ERR: begin
                if (!EN) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and counters; reset aborts any run in progress immediately.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            lat_cnt_q <= '0;
            pkt_cnt_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            lat_cnt_q <= lat_cnt_d;
            pkt_cnt_q <= pkt_cnt_d;
            done_q    <= done_d;
        end
    end

    noc_lat_stats #(
        .LAT_W (LAT_W),
        .SUM_W (SUM_W)
    ) u_stats (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clear    (stats_clear),
        .update   (stats_update),
        .lat_in   (lat_cnt_q),
        .lat_last (LAT_LAST),
        .lat_min  (LAT_MIN),
        .lat_max  (LAT_MAX),
        .lat_sum  (LAT_SUM)
    );

    // Outputs decode the state register only, so DONE never reaches START/START2 combinationally.
    assign START    = (state_q == PULSE1);
    assign START2   = (state_q == PULSE2);
    assign BUSY     = (state_q == INIT_WAIT) || (state_q == PULSE1) || (state_q == PULSE2) ||
                      (state_q == WAIT_DONE) || (state_q == GAP);
    assign FINISHED = (state_q == FINISH);
    assign ERROR    = (state_q == ERR);
    assign PKT_CNT  = pkt_cnt_q;

endmodule

// File: tb/tb_noc_adder_initiator.sv
// tb/tb_noc_adder_initiator.sv - directed self-checking bench for noc_adder_initiator
module tb_noc_adder_initiator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, en, done;
    int   sel = 0;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   t_en, t_start, t_prev_start, t_done, t_start2;

    logic        start_w[3], start2_w[3], busy_w[3], fin_w[3], err_w[3];
    logic [15:0] pkt_w[3], last_w[3], min_w[3], max_w[3];
    logic [31:0] sum_w[3];

    always @(posedge clk) cyc++;

    noc_adder_initiator u_a (
        .CLK(clk), .RST_N(rst_n), .EN(en && sel == 0), .START(start_w[0]), .START2(start2_w[0]),
        .DONE(done && sel == 0), .BUSY(busy_w[0]), .FINISHED(fin_w[0]), .ERROR(err_w[0]),
        .PKT_CNT(pkt_w[0]), .LAT_LAST(last_w[0]), .LAT_MIN(min_w[0]), .LAT_MAX(max_w[0]),
        .LAT_SUM(sum_w[0])
    );

    noc_adder_initiator #(.NUM_PKT(3)) u_b (
        .CLK(clk), .RST_N(rst_n), .EN(en && sel == 1), .START(start_w[1]), .START2(start2_w[1]),
        .DONE(done && sel == 1), .BUSY(busy_w[1]), .FINISHED(fin_w[1]), .ERROR(err_w[1]),
        .PKT_CNT(pkt_w[1]), .LAT_LAST(last_w[1]), .LAT_MIN(min_w[1]), .LAT_MAX(max_w[1]),
        .LAT_SUM(sum_w[1])
    );

    noc_adder_initiator #(.NUM_PKT(4), .INIT_DELAY(0), .GAP_CYCLES(0)) u_c (
        .CLK(clk), .RST_N(rst_n), .EN(en && sel == 2), .START(start_w[2]), .START2(start2_w[2]),
        .DONE(done && sel == 2), .BUSY(busy_w[2]), .FINISHED(fin_w[2]), .ERROR(err_w[2]),
        .PKT_CNT(pkt_w[2]), .LAT_LAST(last_w[2]), .LAT_MIN(min_w[2]), .LAT_MAX(max_w[2]),
        .LAT_SUM(sum_w[2])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_start();
        for (int k = 0; k < 200; k++) begin
            if (start_w[sel]) break;
            @(negedge clk);
        end
        chk("start_seen", {31'd0, start_w[sel]}, 32'd1);
        chk("start2_lo", {31'd0, start2_w[sel]}, 32'd0);
        t_prev_start = t_start;
        t_start      = cyc;
    endtask

    // One packet: START, START2 next cycle, DONE d+1 cycles after START2, then stats check.
    task automatic run_pkt(input int d, input int exp_lat, input int exp_cnt, input bit hold);
        wait_start();
        @(negedge clk);
        chk("start_lo", {31'd0, start_w[sel]}, 32'd0);
        chk("start2_hi", {31'd0, start2_w[sel]}, 32'd1);
        repeat (d + 1) @(negedge clk);
        done   = 1'b1;
        t_done = cyc;
        @(negedge clk);
        if (!hold) done = 1'b0;
        chk("lat_last", {16'd0, last_w[sel]}, exp_lat);
        chk("pkt_cnt", {16'd0, pkt_w[sel]}, exp_cnt);
    endtask

    initial begin
        int lat2[3];
        int dly2[3];
        int t_gap_done;
        dly2  = '{1, 3, 9};
        lat2  = '{3, 5, 11};
        rst_n = 1'b0;
        en    = 1'b0;
        done  = 1'b0;
        t_start = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, busy_w[0]}, 0);
        chk("rst_start", {31'd0, start_w[0]}, 0);
        chk("rst_fin", {31'd0, fin_w[0]}, 0);
        chk("rst_err", {31'd0, err_w[0]}, 0);
        chk("rst_pkt", {16'd0, pkt_w[0]}, 0);
        chk("rst_min", {16'd0, min_w[0]}, 32'hffff);
        chk("rst_max", {16'd0, max_w[0]}, 0);
        chk("rst_sum", sum_w[0], 0);
        rst_n = 1'b1;

        // Defaults: ten packets with latency 7, init delay 12, gap 2
        @(negedge clk);
        en   = 1'b1;
        t_en = cyc;
        for (int p = 1; p <= 10; p++) begin
            t_gap_done = t_done;
            run_pkt(5, 7, p, 1'b0);
            if (p == 1) chk("init_delay", t_start - t_en, 13);
            else        chk("gap", t_start - t_gap_done, 3);
        end
        chk("t1_fin", {31'd0, fin_w[0]}, 1);
        chk("t1_err", {31'd0, err_w[0]}, 0);
        chk("t1_busy", {31'd0, busy_w[0]}, 0);
        chk("t1_min", {16'd0, min_w[0]}, 7);
        chk("t1_max", {16'd0, max_w[0]}, 7);
        chk("t1_sum", sum_w[0], 70);
        en = 1'b0;
        @(negedge clk);
        chk("t1_idle", {31'd0, fin_w[0]}, 0);

        // DONE stuck high: packet 1 completes, packet 2 hits the watchdog
        en = 1'b1;
        run_pkt(3, 5, 1, 1'b1);
        wait_start();
        @(negedge clk);
        t_start2 = cyc;
        for (int k = 0; k < 1100; k++) begin
            @(negedge clk);
            if (err_w[0]) break;
        end
        chk("t3_err", {31'd0, err_w[0]}, 1);
        chk("t3_timeout_cycles", cyc - t_start2, 1024);
        chk("t3_pkt", {16'd0, pkt_w[0]}, 1);
        chk("t3_last", {16'd0, last_w[0]}, 5);
        chk("t3_sum", sum_w[0], 5);
        chk("t3_busy", {31'd0, busy_w[0]}, 0);
        done = 1'b0;
        en   = 1'b0;
        @(negedge clk);
        chk("t3_idle_err", {31'd0, err_w[0]}, 0);
        chk("t3_idle_busy", {31'd0, busy_w[0]}, 0);

        // Asynchronous reset in WAIT_DONE of packet 4
        en = 1'b1;
        for (int p = 1; p <= 3; p++) run_pkt(5, 7, p, 1'b0);
        wait_start();
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("t5_busy", {31'd0, busy_w[0]}, 0);
        chk("t5_pkt", {16'd0, pkt_w[0]}, 0);
        chk("t5_min", {16'd0, min_w[0]}, 32'hffff);
        chk("t5_last", {16'd0, last_w[0]}, 0);
        chk("t5_sum", sum_w[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        en = 1'b1;
        run_pkt(5, 7, 1, 1'b0);
        chk("t5_sum_fresh", sum_w[0], 7);

        // EN toggled mid-run has no effect; FINISH holds while EN stays high
        en = 1'b0;
        for (int p = 2; p <= 10; p++) begin
            run_pkt(5, 7, p, 1'b0);
            if (p == 5) en = 1'b1;
        end
        chk("t6_fin", {31'd0, fin_w[0]}, 1);
        chk("t6_sum", sum_w[0], 70);
        repeat (3) @(negedge clk);
        chk("t6_fin_hold", {31'd0, fin_w[0]}, 1);
        en = 1'b0;
        @(negedge clk);
        chk("t6_idle_fin", {31'd0, fin_w[0]}, 0);
        chk("t6_idle_pkt", {16'd0, pkt_w[0]}, 10);
        en = 1'b1;
        @(negedge clk);
        chk("t6_clr_pkt", {16'd0, pkt_w[0]}, 0);
        chk("t6_clr_min", {16'd0, min_w[0]}, 32'hffff);
        chk("t6_clr_busy", {31'd0, busy_w[0]}, 1);
        en = 1'b0;
        @(negedge clk);

        // Variable latencies on a three-packet instance
        sel = 1;
        @(negedge clk);
        en = 1'b1;
        for (int p = 0; p < 3; p++) begin
            t_gap_done = t_done;
            run_pkt(dly2[p], lat2[p], p + 1, 1'b0);
            if (p > 0) chk("t2_gap", t_start - t_gap_done, 3);
        end
        chk("t2_min", {16'd0, min_w[1]}, 3);
        chk("t2_max", {16'd0, max_w[1]}, 11);
        chk("t2_sum", sum_w[1], 19);
        chk("t2_fin", {31'd0, fin_w[1]}, 1);
        en = 1'b0;
        @(negedge clk);

        // No init delay, no gap, DONE in the first WAIT_DONE cycle
        sel = 2;
        @(negedge clk);
        en   = 1'b1;
        t_en = cyc;
        for (int p = 1; p <= 4; p++) begin
            run_pkt(0, 2, p, 1'b0);
            if (p == 1) chk("t4_first_start", t_start - t_en, 1);
            else        chk("t4_start_spacing", t_start - t_prev_start, 3);
        end
        chk("t4_fin", {31'd0, fin_w[2]}, 1);
        chk("t4_min", {16'd0, min_w[2]}, 2);
        chk("t4_max", {16'd0, max_w[2]}, 2);
        chk("t4_sum", sum_w[2], 8);
        en = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
